mlaccel_memarb: RTL and testbench

Two-port arbiter in front of mlaccel_memory. It shares the single memory port between the host command path (QPI wmem/rmem traffic) and the compute sequencer.
- Compute has priority for throughput.
- The host is guaranteed service through an aging counter.
- Read data is routed back to whichever requester issued the read.

---
 rtl/mlaccel_pkg.sv | 33 +++
 rtl/mlaccel_memarb_age.sv | 46 ++++
 rtl/mlaccel_memarb.sv | 162 ++++++++++++++++
 tb/tb_mlaccel_memarb.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mlaccel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mlaccel_pkg
//  Brief    : Shared constants and types for the mlaccel memory path:
//             address/read-data widths, byte-enable encodings and the
//             arbiter grant type.
//  Revision : 1.0  initial release
// ============================================================================
package mlaccel_pkg;

    localparam int MLACCEL_AW  = 16;
    localparam int MLACCEL_RDW = 64;

    // Byte write-enable encodings on the 16-bit memory write port
    localparam logic [1:0] WEN_READ = 2'b00;
    localparam logic [1:0] WEN_LO   = 2'b01;
    localparam logic [1:0] WEN_HI   = 2'b10;
    localparam logic [1:0] WEN_BOTH = 2'b11;

    // Which requester owns the memory port in the current cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_HOST = 2'b01,
        GNT_COMP = 2'b10
    } gnt_e;

    // A request with no byte enables set is a read
    function automatic logic is_read(input logic [1:0] wen);
        return (wen == WEN_READ);
    endfunction

endpackage : mlaccel_pkg
`default_nettype wire

// File: rtl/mlaccel_memarb_age.sv
`default_nettype none
// ============================================================================
//  Module   : mlaccel_memarb_age
//  Brief    : Host aging counter for the memory arbiter. Counts consecutive
//             cycles the host is stalled and raises force_o once the count
//             reaches MAX_WAIT, which bounds host starvation by compute.
//  Revision : 1.0  initial release
// ============================================================================
module mlaccel_memarb_age #(
    parameter int MAX_WAIT = 4
) (
    input  logic clock,
    input  logic resetn,
    input  logic h_valid_i,
    input  logic h_grant_i,
    output logic force_o
);

    localparam logic [3:0] C_MAX_AGE = 4'(MAX_WAIT);

    logic [3:0] age_q;
    logic [3:0] age_d;

    // Next age: clear when the host is idle or served, else count up to the cap
    always_comb begin
        age_d = age_q;
        if (!h_valid_i || h_grant_i) begin
            age_d = 4'd0;
        end else if (age_q < C_MAX_AGE) begin
            age_d = age_q + 4'd1;
        end
    end

    // Age register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            age_q <= 4'd0;
        end else begin
            age_q <= age_d;
        end
    end

    assign force_o = h_valid_i && (age_q == C_MAX_AGE);

endmodule : mlaccel_memarb_age
`default_nettype wire

// File: rtl/mlaccel_memarb.sv
`default_nettype none
// ============================================================================
//  Module   : mlaccel_memarb
//  Brief    : Two-port arbiter sharing the mlaccel_memory port between the
//             host command path and the compute sequencer. Compute has
//             priority; the host is force-granted after MAX_WAIT stalled
//             cycles. Read data is routed back to the issuing requester one
//             cycle after the grant.
//  Options  : `define MLACCEL_MEMARB_STATS_EN adds saturating stall/forced
//             statistics outputs (stat_host_stall, stat_forced).
//  Revision : 1.0  initial release
// ============================================================================
module mlaccel_memarb
    import mlaccel_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int AW       = MLACCEL_AW
) (
    input  logic                   clock,
    input  logic                   resetn,

    input  logic                   h_valid,
    output logic                   h_ready,
    input  logic [AW-1:0]          h_addr,
    input  logic [1:0]             h_wen,
    input  logic [15:0]            h_wdata,
    output logic                   h_rvalid,
    output logic [MLACCEL_RDW-1:0] h_rdata,

    input  logic                   c_valid,
    output logic                   c_ready,
    input  logic [AW-1:0]          c_addr,
    input  logic [1:0]             c_wen,
    input  logic [15:0]            c_wdata,
    output logic                   c_rvalid,
    output logic [MLACCEL_RDW-1:0] c_rdata,

    output logic [AW-1:0]          mem_addr,
    output logic [1:0]             mem_wen,
    output logic [15:0]            mem_wdata,
    input  logic [MLACCEL_RDW-1:0] mem_rdata
`ifdef MLACCEL_MEMARB_STATS_EN
    ,
    output logic [15:0]            stat_host_stall,
    output logic [15:0]            stat_forced
`endif
);

    logic w_force;
    gnt_e w_gnt_raw;   // decision from request inputs alone
    gnt_e w_gnt;       // decision as seen outside, suppressed during reset
    logic w_h_grant;
    logic rd_h_q, rd_h_d;
    logic rd_c_q, rd_c_d;

    // Starvation guard: host age tracking and force decision
    mlaccel_memarb_age #(
        .MAX_WAIT (MAX_WAIT)
    ) u_age (
        .clock     (clock),
        .resetn    (resetn),
        .h_valid_i (h_valid),
        .h_grant_i (w_h_grant),
        .force_o   (w_force)
    );

    // Grant decision: compute first unless the host has aged out
    always_comb begin
        w_gnt_raw = GNT_NONE;
        if (c_valid && !w_force) begin
            w_gnt_raw = GNT_COMP;
        end else if (h_valid) begin
            w_gnt_raw = GNT_HOST;
        end
    end

    // State updates are already frozen by the async reset, so only the
    // visible handshake needs explicit suppression while resetn is low.
    assign w_h_grant = (w_gnt_raw == GNT_HOST);
    assign w_gnt     = resetn ? w_gnt_raw : GNT_NONE;
    assign h_ready   = (w_gnt == GNT_HOST);
    assign c_ready   = (w_gnt == GNT_COMP);

    // Memory port mux; the idle bus parks at all-zero
    always_comb begin
        mem_addr  = '0;
        mem_wen   = WEN_READ;
        mem_wdata = '0;
        case (w_gnt)
            GNT_HOST: begin
                mem_addr  = h_addr;
                mem_wen   = h_wen;
                mem_wdata = h_wdata;
            end
            GNT_COMP: begin
                mem_addr  = c_addr;
                mem_wen   = c_wen;
                mem_wdata = c_wdata;
            end
            default: begin
                mem_addr  = '0;
                mem_wen   = WEN_READ;
                mem_wdata = '0;
            end
        endcase
    end

    // Remember which requester issued a read so its response is routed back
    always_comb begin
        rd_h_d = (w_gnt_raw == GNT_HOST) && is_read(h_wen);
        rd_c_d = (w_gnt_raw == GNT_COMP) && is_read(c_wen);
    end

    // Read-ownership flags; reset drops any response still in flight
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_h_q <= 1'b0;
            rd_c_q <= 1'b0;
        end else begin
            rd_h_q <= rd_h_d;
            rd_c_q <= rd_c_d;
        end
    end

    assign h_rvalid = rd_h_q;
    assign c_rvalid = rd_c_q;
    assign h_rdata  = mem_rdata;
    assign c_rdata  = mem_rdata;

`ifdef MLACCEL_MEMARB_STATS_EN
    logic [15:0] stall_q, stall_d;
    logic [15:0] forced_q, forced_d;

    // Saturating counters: host stall cycles and host grants taken from compute
    always_comb begin
        stall_d  = stall_q;
        forced_d = forced_q;
        if (h_valid && (w_gnt_raw != GNT_HOST) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
        if ((w_gnt_raw == GNT_HOST) && c_valid && (forced_q != 16'hFFFF)) begin
            forced_d = forced_q + 16'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_q  <= 16'd0;
            forced_q <= 16'd0;
        end else begin
            stall_q  <= stall_d;
            forced_q <= forced_d;
        end
    end

    assign stat_host_stall = stall_q;
    assign stat_forced     = forced_q;
`endif

endmodule : mlaccel_memarb
`default_nettype wire

// File: tb/tb_mlaccel_memarb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mlaccel_memarb
//  Brief    : Self-checking bench for mlaccel_memarb. A transaction-level
//             reference (stall count, expected owner of the next read
//             response, shadow memory) predicts every handshake, bus value
//             and read response; a memory model answers on mem_*.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mlaccel_memarb;
    import mlaccel_pkg::*;

    localparam int MAX_WAIT = 4;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        h_valid = 1'b0, c_valid = 1'b0;
    logic [15:0] h_addr = '0, c_addr = '0, h_wdata = '0, c_wdata = '0;
    logic [1:0]  h_wen = '0, c_wen = '0;
    logic        h_ready, c_ready, h_rvalid, c_rvalid;
    logic [63:0] h_rdata, c_rdata, mem_rdata;
    logic [15:0] mem_addr, mem_wdata;
    logic [1:0]  mem_wen;
`ifdef MLACCEL_MEMARB_STATS_EN
    logic [15:0] stat_host_stall, stat_forced;
`endif

    mlaccel_memarb #(.MAX_WAIT(MAX_WAIT), .AW(16)) dut (
        .clock(clock), .resetn(resetn),
        .h_valid(h_valid), .h_ready(h_ready), .h_addr(h_addr), .h_wen(h_wen),
        .h_wdata(h_wdata), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .c_valid(c_valid), .c_ready(c_ready), .c_addr(c_addr), .c_wen(c_wen),
        .c_wdata(c_wdata), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef MLACCEL_MEMARB_STATS_EN
        , .stat_host_stall(stat_host_stall), .stat_forced(stat_forced)
`endif
    );

    always #5 clock = ~clock;

    // Read word returned for an address: mixes the address in so a
    // misrouted address shows up even when stored words coincide.
    function automatic logic [63:0] rd_word(input logic [15:0] a, input logic [15:0] w);
        return {a, ~w, a ^ 16'h1234, w};
    endfunction

    function automatic logic [15:0] init_word(input int a);
        return 16'(a) ^ 16'h3C3C;
    endfunction

    // Memory model driven by the DUT's bus, one-cycle read latency
    logic [15:0] env_mem [0:65535];
    logic [63:0] env_rdata;
    bit          env_ready = 1'b0;
    assign mem_rdata = env_rdata;

    always @(posedge clock) begin
        if (!env_ready) begin
            for (int i = 0; i < 65536; i++) env_mem[i] <= init_word(i);
            env_ready <= 1'b1;
        end else begin
            if (mem_wen[0]) env_mem[mem_addr][7:0]  <= mem_wdata[7:0];
            if (mem_wen[1]) env_mem[mem_addr][15:8] <= mem_wdata[15:8];
        end
        env_rdata <= rd_word(mem_addr, env_mem[mem_addr]);
    end

    // ---------------- reference model state ----------------
    logic [15:0] ref_mem [0:65535];
    int          m_wait   = 0;     // consecutive stalled host cycles
    bit          m_rvh    = 1'b0, m_rvc = 1'b0;
    logic [63:0] m_dh     = '0, m_dc = '0;
    bit          m_gh     = 1'b0, m_gc = 1'b0;
    int          m_stall  = 0, m_forced = 0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs at negedge, check just after, advance model
    task automatic do_cycle(input bit rn,
                            input bit hv, input logic [15:0] ha, input logic [1:0] hw, input logic [15:0] hd,
                            input bit cv, input logic [15:0] ca, input logic [1:0] cw, input logic [15:0] cd);
        bit          gh, gc, frc;
        logic [15:0] ea, ed;
        logic [1:0]  ew;
        @(negedge clock);
        resetn = rn;
        h_valid = hv; h_addr = ha; h_wen = hw; h_wdata = hd;
        c_valid = cv; c_addr = ca; c_wen = cw; c_wdata = cd;
        #1;
        if (!rn) begin
            gh = 1'b0; gc = 1'b0;
            m_rvh = 1'b0; m_rvc = 1'b0;
            m_stall = 0; m_forced = 0;
        end else begin
            frc = hv && (m_wait == MAX_WAIT);
            gc  = cv && !frc;
            gh  = hv && !gc;
        end
        check_eq("c_ready", c_ready, gc);
        check_eq("h_ready", h_ready, gh);
        ea = gc ? ca : (gh ? ha : 16'h0);
        ew = gc ? cw : (gh ? hw : 2'b00);
        ed = gc ? cd : (gh ? hd : 16'h0);
        check_eq("mem_addr",  mem_addr,  ea);
        check_eq("mem_wen",   mem_wen,   ew);
        check_eq("mem_wdata", mem_wdata, ed);
        check_eq("h_rvalid", h_rvalid, m_rvh);
        check_eq("c_rvalid", c_rvalid, m_rvc);
        if (m_rvh) check_eq("h_rdata", h_rdata, m_dh);
        if (m_rvc) check_eq("c_rdata", c_rdata, m_dc);
`ifdef MLACCEL_MEMARB_STATS_EN
        check_eq("stat_host_stall", stat_host_stall, m_stall);
        check_eq("stat_forced",     stat_forced,     m_forced);
`endif
        if (rn) begin
            if (hv && !gh && m_stall < 65535) m_stall++;
            if (gh && cv && m_forced < 65535) m_forced++;
        end
        m_rvh = gh && (hw == 2'b00);
        m_rvc = gc && (cw == 2'b00);
        m_dh  = rd_word(ha, ref_mem[ha]);
        m_dc  = rd_word(ca, ref_mem[ca]);
        if (gh) begin
            if (hw[0]) ref_mem[ha][7:0]  = hd[7:0];
            if (hw[1]) ref_mem[ha][15:8] = hd[15:8];
        end
        if (gc) begin
            if (cw[0]) ref_mem[ca][7:0]  = cd[7:0];
            if (cw[1]) ref_mem[ca][15:8] = cd[15:8];
        end
        if (!rn || !hv || gh) m_wait = 0;
        else if (m_wait < MAX_WAIT) m_wait++;
        m_gh = gh; m_gc = gc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int          hgrants;
        bit          hv, cv;
        logic [15:0] ha, hd, ca, cd;
        logic [1:0]  hw, cw;

        for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);

        // Reset with both requesters asserting valid: nothing may be granted
        for (int i = 0; i < 3; i++) do_cycle(0, 1, 16'h0001, 2'b00, 0, 1, 16'h0002, 2'b11, 16'h1111);
        idle(2);

        // Host alone: write 0xBEEF to 0x0010, read it back
        do_cycle(1, 1, 16'h0010, WEN_BOTH, 16'hBEEF, 0, 0, 0, 0);
        do_cycle(1, 1, 16'h0010, WEN_READ, 16'h0000, 0, 0, 0, 0);
        idle(1);
        check_eq("host_readback_lo", h_rdata[15:0], 16'hBEEF);
        idle(1);

        // Continuous contention: host reads 0x0200, compute reads 0x0100+
        hgrants = 0;
        for (int i = 0; i < 20; i++) begin
            do_cycle(1, 1, 16'h0200, WEN_READ, 0, 1, 16'h0100 + 16'(i), WEN_READ, 0);
            if (h_ready) hgrants++;
        end
        check_eq("forced_host_grants", hgrants, 4);
        idle(2);

        // Compute writes then back-to-back reads of 0x0000..0x0007
        for (int i = 0; i < 8; i++) do_cycle(1, 0, 0, 0, 0, 1, 16'(i), WEN_LO, 16'hA500 + 16'(i));
        for (int i = 0; i < 8; i++) do_cycle(1, 0, 0, 0, 0, 1, 16'(i), WEN_READ, 0);
        idle(2);

        // Build host age, issue a read, then reset while its response is due
        for (int i = 0; i < 3; i++) do_cycle(1, 1, 16'h0300, WEN_READ, 0, 1, 16'h0040, WEN_READ, 0);
        for (int i = 0; i < 2; i++) do_cycle(0, 1, 16'h0300, WEN_READ, 0, 1, 16'h0041, WEN_READ, 0);
        for (int i = 0; i < 6; i++) do_cycle(1, 1, 16'h0300, WEN_READ, 0, 1, 16'h0050 + 16'(i), WEN_HI, 16'h7E00);
        idle(2);

        // Randomized traffic on a small address window, honouring the hold rule
        hv = 0; cv = 0; ha = 0; hd = 0; ca = 0; cd = 0; hw = 0; cw = 0;
        for (int i = 0; i < 500; i++) begin
            if (!(hv && !m_gh)) begin
                hv = ($urandom_range(0, 3) != 0);
                ha = 16'($urandom_range(0, 31));
                hw = 2'($urandom_range(0, 3));
                hd = 16'($urandom);
            end
            if (!(cv && !m_gc)) begin
                cv = ($urandom_range(0, 4) != 0);
                ca = 16'($urandom_range(0, 31));
                cw = 2'($urandom_range(0, 3));
                cd = 16'($urandom);
            end
            do_cycle(1, hv, ha, hw, hd, cv, ca, cw, cd);
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mlaccel_memarb
`default_nettype wire
